// File: rtl/keyb_scanner.sv
// keyb_scanner: 4x4 active-low keypad scanner with column dwell and filtered release
module keyb_scanner #(
    parameter int SCAN_DIV    = 3000,
    parameter int RELEASE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       btn_press,
    output logic [3:0] key_code
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(RELEASE_CNT + 1);

    typedef enum logic {SCAN, HOLD} state_t;

    state_t        state;
    logic [3:0]    row_m, row_s;
    logic [CW-1:0] dwell;
    logic [RW-1:0] rel;
    logic [1:0]    held_row, col_idx, win_row;
    logic          sample, any_low, held_high;

    assign sample    = dwell == CW'(SCAN_DIV - 1);
    assign any_low   = row_s != 4'hF;
    assign held_high = row_s[held_row];

    // index of the driven column and the highest-priority (lowest-index) low row
    always_comb begin
        col_idx = !col_out[0] ? 2'd0 : !col_out[1] ? 2'd1 : !col_out[2] ? 2'd2 : 2'd3;
        win_row = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
    end

    // two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            row_m <= '0;
            row_s <= '0;
        end else begin
            row_m <= row_in;
            row_s <= row_m;
        end

    // free-running dwell counter; its terminal count marks the sample point
    always_ff @(posedge clk or posedge reset)
        if (reset) dwell <= '0;
        else       dwell <= sample ? '0 : dwell + 1'b1;

    // scan/hold state machine with registered outputs, acting only at sample points
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= SCAN;
            col_out   <= 4'b1110;
            btn_press <= 1'b0;
            key_code  <= 4'h0;
            held_row  <= 2'd0;
            rel       <= '0;
        end else if (sample) begin
            if (state == SCAN) begin
                if (any_low) begin
                    state     <= HOLD;
                    held_row  <= win_row;
                    key_code  <= {win_row, col_idx};
                    btn_press <= 1'b1;
                end else begin
                    col_out <= {col_out[2:0], col_out[3]};
                end
            end else if (!held_high) begin
                rel <= '0;
            end else if (rel == RW'(RELEASE_CNT - 1)) begin
                rel       <= '0;
                btn_press <= 1'b0;
                col_out   <= {col_out[2:0], col_out[3]};
                state     <= SCAN;
            end else begin
                rel <= rel + 1'b1;
            end
        end
endmodule

// File: tb/tb_keyb_scanner.sv
// tb_keyb_scanner: keypad-matrix stimulus checked against a sample-point reference model
module tb_keyb_scanner;
    localparam int SD = 8;
    localparam int RC = 4;

    typedef struct {
        logic [15:0] keys;
        int          cycles;
        logic [3:0]  col;
        logic        btn;
        logic [3:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_in, col_out, key_code;
    logic        btn_press;
    logic [15:0] keys = '0;
    int          passed = 0;
    int          total = 0;

    int          e, m_col, m_row, m_rel;
    bit          m_hold;
    logic        m_btn;
    logic [3:0]  m_code;
    logic [3:0]  hist [2];

    vec_t vecs [16];

    keyb_scanner #(.SCAN_DIV(SD), .RELEASE_CNT(RC)) dut (
        .clk(clk), .reset(reset), .row_in(row_in),
        .col_out(col_out), .btn_press(btn_press), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // physical keypad: key (r,c) pulls row r low while column c is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got col/btn/code=%b/%b/%h expected %b/%b/%h",
                      name, act[8:5], act[4], act[3:0], exp[8:5], exp[4], exp[3:0]);
    endtask

    task automatic model_reset();
        e = 0; m_col = 0; m_row = 0; m_rel = 0; m_hold = 0; m_btn = 0; m_code = 0;
        hist[0] = 4'h0; hist[1] = 4'h0;
    endtask

    // rows seen at a decision are those present two clocks earlier; decisions every SD clocks
    task automatic model_step(input logic [3:0] r);
        logic [3:0] s;
        int w;
        s = hist[1];
        hist[1] = hist[0];
        hist[0] = r;
        e++;
        if (e % SD == 0) begin
            if (!m_hold) begin
                if (s != 4'hF) begin
                    w = 0;
                    for (int i = 3; i >= 0; i--) if (!s[i]) w = i;
                    m_hold = 1; m_row = w; m_btn = 1; m_rel = 0;
                    m_code = 4'(w * 4 + m_col);
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (s[m_row]) begin
                m_rel++;
                if (m_rel == RC) begin
                    m_rel = 0; m_btn = 0; m_hold = 0;
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    task automatic step(input string name);
        logic [3:0] r;
        @(negedge clk);
        r = row_in;
        @(posedge clk);
        model_step(r);
        #1 cmp(name, {col_out, btn_press, key_code}, {4'hF ^ 4'(1 << m_col), m_btn, m_code});
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 cmp("reset_async", {col_out, btn_press, key_code}, {4'b1110, 1'b0, 4'h0});
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        int n;
        int pick;
        vecs = '{
            '{16'h0000,  7, 4'b1110, 1'b0, 4'h0},
            '{16'h0000,  1, 4'b1101, 1'b0, 4'h0},
            '{16'h0000,  8, 4'b1011, 1'b0, 4'h0},
            '{16'h0000,  8, 4'b0111, 1'b0, 4'h0},
            '{16'h0000,  8, 4'b1110, 1'b0, 4'h0},
            '{16'h0000,  8, 4'b1101, 1'b0, 4'h0},
            '{16'h0200,  7, 4'b1101, 1'b0, 4'h0},
            '{16'h0200,  1, 4'b1101, 1'b1, 4'h9},
            '{16'h0000, 16, 4'b1101, 1'b1, 4'h9},
            '{16'h0200,  8, 4'b1101, 1'b1, 4'h9},
            '{16'h0000, 31, 4'b1101, 1'b1, 4'h9},
            '{16'h0000,  1, 4'b1011, 1'b0, 4'h9},
            '{16'h8080, 15, 4'b0111, 1'b0, 4'h9},
            '{16'h8080,  1, 4'b0111, 1'b1, 4'h7},
            '{16'h8000, 31, 4'b0111, 1'b1, 4'h7},
            '{16'h8000,  1, 4'b1110, 1'b0, 4'h7}
        };
        do_reset();
        foreach (vecs[i]) begin
            keys = vecs[i].keys;
            for (int k = 0; k < vecs[i].cycles; k++) step("model");
            cmp($sformatf("vec%0d", i), {col_out, btn_press, key_code},
                {vecs[i].col, vecs[i].btn, vecs[i].code});
        end
        keys = 16'h8000;
        n = 0;
        while (!btn_press && n < 64) begin
            step("model");
            n++;
        end
        cmp("hold_reached", {8'h0, btn_press}, {8'h0, 1'b1});
        do_reset();
        repeat (8) step("model");
        cmp("rotate_after_reset", {col_out, btn_press, key_code}, {4'b1101, 1'b0, 4'h0});
        repeat (23) step("model");
        cmp("no_press_before_col3", {col_out, btn_press, key_code}, {4'b0111, 1'b0, 4'h0});
        step("model");
        cmp("redetect_col3", {col_out, btn_press, key_code}, {4'b0111, 1'b1, 4'hF});
        repeat (60) begin
            pick = $urandom_range(0, 9);
            keys = pick < 4 ? 16'h0 : pick < 8 ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            repeat ($urandom_range(1, 50)) step("rand");
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
